// File: rtl/chacha_pkg.sv
// Shared constants, FSM encoding and quarter-round index tables for the
// iterative ChaCha block core.
package chacha_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 16;
  localparam int N_QR    = 4;

  // "expand 32-byte k" as four little-endian words
  localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
  localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
  localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
  localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  typedef logic [3:0] qr_idx_t [N_QR][4];

  // Each row lists the (a, b, c, d) state word indices for one quarter round
  localparam qr_idx_t COL_IDX = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam qr_idx_t DIAG_IDX = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter round: four add/xor/rotate steps on a,b,c,d.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic [WORD_W-1:0] i_c,
  input  logic [WORD_W-1:0] i_d,
  output logic [WORD_W-1:0] o_a,
  output logic [WORD_W-1:0] o_b,
  output logic [WORD_W-1:0] o_c,
  output logic [WORD_W-1:0] o_d
);

  logic [WORD_W-1:0] w_a1, w_d1x, w_d1, w_c1, w_b1x, w_b1;
  logic [WORD_W-1:0] w_a2, w_d2x, w_d2, w_c2, w_b2x, w_b2;

  // Fixed left rotates are pure wiring: 16, 12, 8, 7
  assign w_a1  = i_a + i_b;
  assign w_d1x = i_d ^ w_a1;
  assign w_d1  = {w_d1x[15:0], w_d1x[31:16]};
  assign w_c1  = i_c + w_d1;
  assign w_b1x = i_b ^ w_c1;
  assign w_b1  = {w_b1x[19:0], w_b1x[31:20]};

  assign w_a2  = w_a1 + w_b1;
  assign w_d2x = w_d1 ^ w_a2;
  assign w_d2  = {w_d2x[23:0], w_d2x[31:24]};
  assign w_c2  = w_c1 + w_d2;
  assign w_b2x = w_b1 ^ w_c2;
  assign w_b2  = {w_b2x[24:0], w_b2x[31:25]};

  assign o_a = w_a2;
  assign o_b = w_b2;
  assign o_c = w_c2;
  assign o_d = w_d2;

endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one column or diagonal round per cycle,
// final feed-forward add, and a valid/ready held output block.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [255:0] key_i,
  input  logic [95:0]  nonce_i,
  input  logic [31:0]  counter_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [511:0] block_o,
  output logic [1:0]   dbg_state_o
);

  // Handshake: block_o is transferred on a rising edge where valid_o and
  // ready_i are both high; valid_o then drops and block_o keeps its value.
  // start_i is only honoured while ready_o is high (IDLE).

  localparam int RND_W = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  state_t              r_state;
  logic [RND_W-1:0]    r_rnd;
  logic [WORD_W-1:0]   r_init [N_WORDS];
  logic [WORD_W-1:0]   r_work [N_WORDS];
  logic [511:0]        r_block;
  logic                r_ready;
  logic                r_busy;
  logic                r_valid;

  logic [WORD_W-1:0]   w_seed [N_WORDS];
  logic [WORD_W-1:0]   w_next [N_WORDS];
  logic [3:0]          w_sel  [N_QR][4];
  logic [WORD_W-1:0]   w_qa [N_QR];
  logic [WORD_W-1:0]   w_qb [N_QR];
  logic [WORD_W-1:0]   w_qc [N_QR];
  logic [WORD_W-1:0]   w_qd [N_QR];
  logic [WORD_W-1:0]   w_ra [N_QR];
  logic [WORD_W-1:0]   w_rb [N_QR];
  logic [WORD_W-1:0]   w_rc [N_QR];
  logic [WORD_W-1:0]   w_rd [N_QR];
  logic [511:0]        w_sum;

  always_comb begin
    w_seed[0] = SIGMA0;
    w_seed[1] = SIGMA1;
    w_seed[2] = SIGMA2;
    w_seed[3] = SIGMA3;
    for (int k = 0; k < 8; k++) begin
      w_seed[4+k] = key_i[32*k +: 32];
    end
    w_seed[12] = counter_i;
    for (int n = 0; n < 3; n++) begin
      w_seed[13+n] = nonce_i[32*n +: 32];
    end
  end

  // Even rounds work on columns, odd rounds on diagonals
  always_comb begin
    for (int q = 0; q < N_QR; q++) begin
      for (int p = 0; p < 4; p++) begin
        w_sel[q][p] = r_rnd[0] ? DIAG_IDX[q][p] : COL_IDX[q][p];
      end
    end
  end

  always_comb begin
    for (int q = 0; q < N_QR; q++) begin
      w_qa[q] = r_work[w_sel[q][0]];
      w_qb[q] = r_work[w_sel[q][1]];
      w_qc[q] = r_work[w_sel[q][2]];
      w_qd[q] = r_work[w_sel[q][3]];
    end
  end

  for (genvar g = 0; g < N_QR; g++) begin : g_qr
    chacha_quarter_round u_qr (
      .i_a (w_qa[g]),
      .i_b (w_qb[g]),
      .i_c (w_qc[g]),
      .i_d (w_qd[g]),
      .o_a (w_ra[g]),
      .o_b (w_rb[g]),
      .o_c (w_rc[g]),
      .o_d (w_rd[g])
    );
  end

  // The four quarter rounds of one step touch disjoint words, so every
  // word is overwritten exactly once; the default only keeps this latch-free.
  always_comb begin
    for (int i = 0; i < N_WORDS; i++) begin
      w_next[i] = r_work[i];
    end
    for (int q = 0; q < N_QR; q++) begin
      w_next[w_sel[q][0]] = w_ra[q];
      w_next[w_sel[q][1]] = w_rb[q];
      w_next[w_sel[q][2]] = w_rc[q];
      w_next[w_sel[q][3]] = w_rd[q];
    end
  end

  always_comb begin
    for (int i = 0; i < N_WORDS; i++) begin
      w_sum[32*i +: 32] = r_work[i] + r_init[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_rnd   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_block <= '0;
      for (int i = 0; i < N_WORDS; i++) begin
        r_init[i] <= '0;
        r_work[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            for (int i = 0; i < N_WORDS; i++) begin
              r_init[i] <= w_seed[i];
              r_work[i] <= w_seed[i];
            end
            r_rnd   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          for (int i = 0; i < N_WORDS; i++) begin
            r_work[i] <= w_next[i];
          end
          r_rnd <= r_rnd + RND_W'(1);
          if (r_rnd == LAST_RND) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          r_block <= w_sum;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign busy_o      = r_busy;
  assign valid_o     = r_valid;
  assign block_o     = r_block;
  assign dbg_state_o = r_state;

endmodule
